bcd_updown_counter: RTL and testbench

Parametrised multi-digit synchronous BCD counter that generalises the team's single-digit 0–9 counter. It counts up or down across DIGITS cascaded decimal digits, supports a synchronous parallel load with digit validation, and flags terminal count and wrap events. It drives decimal displays, timers and event tallies that need more than one decade and reversible counting.

---
 rtl/bcd_updown_counter.sv | 131 +++++++++++++
 tb/tb_bcd_updown_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
//
// Multi-digit synchronous BCD up/down counter with synchronous parallel load.
// Digit 0 is the least significant decade and sits in q[3:0]. Carry and
// borrow resolve across every digit in a single cycle.
//
// Build option:
//   BCD_SATURATE_EN  when defined, counting holds at 99..9 (up) or 00..0
//                    (down) instead of wrapping; wrap then pulses on each
//                    blocked step.
//
// Parameters:
//   DIGITS    number of BCD digits (1..8)
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high; clears q, wrap and load_err
//   en        count enable, one step per cycle while high
//   up        direction, 1 = increment, 0 = decrement
//   load      parallel load request (overrides en)
//   load_val  value to load, one BCD digit per nibble
//   q         current count (the state register itself)
//   tc        terminal count, combinational from q and up
//   wrap      one-cycle pulse after a wrapping (or saturated) step
//   load_err  one-cycle pulse after a load that contained a nibble > 9
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] count_next;
  logic [4*DIGITS-1:0] load_clean;
  logic                load_bad;
  logic                all_nine;
  logic                all_zero;
  logic                carry;
  logic [3:0]          digit;

  // Terminal count: the next step in the current direction would wrap.
  always_comb begin
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (q[4*i +: 4] != 4'd9) all_nine = 1'b0;
      if (q[4*i +: 4] != 4'd0) all_zero = 1'b0;
    end
    tc = up ? all_nine : all_zero;
  end

  // Single-cycle carry/borrow chain: a digit steps only while every lower
  // digit has rolled over. Out-of-range digits (only reachable without a
  // reset) are folded back into 0..9 rather than propagated.
  always_comb begin
    count_next = q;
    carry      = 1'b1;
    digit      = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = q[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (digit >= 4'd9) begin
            count_next[4*i +: 4] = 4'd0;
          end else begin
            count_next[4*i +: 4] = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            count_next[4*i +: 4] = 4'd9;
          end else if (digit > 4'd9) begin
            count_next[4*i +: 4] = 4'd9;
            carry = 1'b0;
          end else begin
            count_next[4*i +: 4] = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  // Load sanitising: illegal nibbles become 0 and raise load_err.
  always_comb begin
    load_clean = load_val;
    load_bad   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_clean[4*i +: 4] = 4'd0;
        load_bad = 1'b1;
      end
    end
  end

  // State register; priority reset > load > en. The pulses default to 0 so
  // they only ever last the single cycle following their cause.
  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      q        <= load_clean;
      wrap     <= 1'b0;
      load_err <= load_bad;
    end else if (en) begin
      wrap     <= tc;
      load_err <= 1'b0;
`ifdef BCD_SATURATE_EN
      if (!tc) q <= count_next;
`else
      q <= count_next;
`endif
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Scoreboard bench for bcd_updown_counter (DIGITS = 4). The stimulus process
// drives inputs on the falling edge and pushes the expected post-edge
// response, computed from an integer model of the count, into a queue. A
// separate monitor pops one entry after every rising edge and compares q,
// wrap, load_err and tc. Honours BCD_SATURATE_EN like the design.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

  localparam int          DIGITS = 4;
  localparam int          W      = 4 * DIGITS;
  localparam int unsigned MODV   = 10000;

  typedef struct packed {
    logic [W-1:0] q;
    logic         wrap;
    logic         load_err;
    logic         tc;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;
  logic         load_err;

  exp_t        exp_q[$];
  int unsigned model_val;
  int          vectors;
  int          miscompares;

  bcd_updown_counter #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer value -> packed BCD digits.
  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal value a load stores: illegal digits count as zero.
  function automatic int unsigned load_value(input logic [W-1:0] lv);
    int unsigned v;
    int unsigned scale;
    v = 0;
    scale = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (lv[4*i +: 4] <= 4'd9) v = v + int'(lv[4*i +: 4]) * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  function automatic bit load_has_bad(input logic [W-1:0] lv);
    bit b;
    b = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (lv[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  // Drive one cycle of inputs and queue the response expected after the edge.
  task automatic applyStimulus(input logic r, input logic l, input logic e,
                               input logic u, input logic [W-1:0] lv);
    exp_t ex;
    @(negedge clk);
    reset    = r;
    load     = l;
    en       = e;
    up       = u;
    load_val = lv;
    ex.wrap     = 1'b0;
    ex.load_err = 1'b0;
    if (r) begin
      model_val = 0;
    end else if (l) begin
      model_val   = load_value(lv);
      ex.load_err = load_has_bad(lv);
    end else if (e) begin
      if (u) begin
        if (model_val == MODV - 1) begin
          ex.wrap = 1'b1;
`ifndef BCD_SATURATE_EN
          model_val = 0;
`endif
        end else begin
          model_val = model_val + 1;
        end
      end else begin
        if (model_val == 0) begin
          ex.wrap = 1'b1;
`ifndef BCD_SATURATE_EN
          model_val = MODV - 1;
`endif
        end else begin
          model_val = model_val - 1;
        end
      end
    end
    ex.q  = to_bcd(model_val);
    ex.tc = u ? (model_val == MODV - 1) : (model_val == 0);
    exp_q.push_back(ex);
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one response per rising edge while expectations are pending.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        checkOutput("q",        q,                     ex.q);
        checkOutput("wrap",     {{(W-1){1'b0}}, wrap},     {{(W-1){1'b0}}, ex.wrap});
        checkOutput("load_err", {{(W-1){1'b0}}, load_err}, {{(W-1){1'b0}}, ex.load_err});
        checkOutput("tc",       {{(W-1){1'b0}}, tc},       {{(W-1){1'b0}}, ex.tc});
      end
    end
  end

  initial begin
    logic [W-1:0] lv;
    int           pick;
    vectors     = 0;
    miscompares = 0;
    model_val   = 0;
    reset    = 1'b1;
    load     = 1'b0;
    en       = 1'b0;
    up       = 1'b1;
    load_val = '0;

    // Reset then count up through a decade boundary.
    applyStimulus(1, 0, 0, 1, '0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 1, '0);

    // Up wrap (or saturation) at 9999.
    applyStimulus(0, 1, 1, 1, 16'h9998);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, '0);

    // Down wrap at 0000, and borrow across three digits.
    applyStimulus(0, 1, 0, 0, 16'h0001);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(0, 1, 0, 0, 16'h1000);
    applyStimulus(0, 0, 1, 0, '0);

    // Illegal nibble load, then hold with en low.
    applyStimulus(0, 1, 0, 1, 16'h12F4);
    applyStimulus(0, 0, 0, 1, '0);
    applyStimulus(0, 0, 0, 0, '0);

    // Direction change mid-count.
    applyStimulus(0, 1, 0, 1, 16'h0047);
    applyStimulus(0, 0, 1, 1, '0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(0, 0, 1, 1, '0);

    // Reset overriding load and en; load overriding en.
    applyStimulus(0, 1, 1, 1, 16'h0777);
    applyStimulus(1, 1, 1, 1, 16'h0555);
    applyStimulus(0, 0, 1, 1, '0);
    applyStimulus(1, 0, 1, 0, '0);
    applyStimulus(0, 1, 1, 0, 16'h4321);

    // Randomised traffic with boundary-biased loads.
    for (int i = 0; i < 400; i++) begin
      pick = int'($urandom_range(0, 99));
      case ($urandom_range(0, 3))
        0:       lv = 16'h9998;
        1:       lv = 16'h0001;
        default: lv = W'($urandom);
      endcase
      if (pick < 2)
        applyStimulus(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), lv);
      else if (pick < 10)
        applyStimulus(0, 1, $urandom_range(0, 1), $urandom_range(0, 1), lv);
      else
        applyStimulus(0, 0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), lv);
    end

    // Drain: everything queued must have been checked by now.
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d responses pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
